// File: rtl/alu8_ctrl.sv
// alu8_ctrl: command-driven initiator for the external 8-bit combinational ALU.
// Holds a small register file, issues register/immediate operations to the ALU,
// captures result and flags, writes the low byte back and returns the full result
// on a valid/ready response handshake. One command in flight at a time.
//
// Build option: define ALU_CTRL_SELFCHECK_EN to add a shadow computation of the
// ALU result in CAPTURE; a disagreement sets the sticky chk_err output.
// Without it chk_err is tied low and the port list is unchanged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high; loads complete here, ALU ops latch operands
// ISSUE   | ALU inputs stable, one settle cycle
// CAPTURE | sample ALU result/flags, write low byte to rd
// RESP    | rsp_valid high until rsp_ready
module alu8_ctrl #(
   parameter int NREG = 4,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_rs1,
   input  logic [AW-1:0] cmd_rs2,
   input  logic          cmd_use_imm,
   input  logic [7:0]    cmd_imm,
   output logic [2:0]    alu_opcode,
   output logic [7:0]    alu_op1,
   output logic [7:0]    alu_op2,
   input  logic [15:0]   alu_result,
   input  logic          alu_flagc,
   input  logic          alu_flagz,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [15:0]   rsp_result,
   output logic          rsp_flagc,
   output logic          rsp_flagz,
   input  logic [AW-1:0] dbg_addr,
   output logic [7:0]    dbg_data,
   output logic          chk_err
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      regs_q [NREG];
   logic [7:0]      regs_d [NREG];
   logic [2:0]      opc_q, opc_d;
   logic [7:0]      op1_q, op1_d;
   logic [7:0]      op2_q, op2_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [15:0]     res_q, res_d;
   logic            fc_q, fc_d;
   logic            fz_q, fz_d;

`ifdef ALU_CTRL_SELFCHECK_EN
   logic            chk_q, chk_d;

   // Reference ALU; logic ops are 8-bit and zero-extended into the 16-bit result.
   function automatic logic [15:0] ref_result(input logic [2:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
      logic [15:0] r;
      case (op)
         3'b000:  r = {8'h00, a} + {8'h00, b};
         3'b001:  r = {8'h00, a} - {8'h00, b};
         3'b010:  r = {8'h00, a} * {8'h00, b};
         3'b011:  r = {8'h00, a & b};
         3'b100:  r = {8'h00, a | b};
         3'b101:  r = {8'h00, ~(a & b)};
         3'b110:  r = {8'h00, ~(a | b)};
         default: r = {8'h00, a ^ b};
      endcase
      return r;
   endfunction
`endif

   // Next-state, register-file writeback and response capture.
   always_comb begin
      state_d = state_q;
      regs_d  = regs_q;
      opc_d   = opc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rd_d    = rd_q;
      res_d   = res_q;
      fc_d    = fc_q;
      fz_d    = fz_q;
`ifdef ALU_CTRL_SELFCHECK_EN
      chk_d   = chk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_load) begin
                  regs_d[cmd_rd] = cmd_imm;
                  res_d          = {8'h00, cmd_imm};
                  fc_d           = 1'b0;
                  fz_d           = (cmd_imm == 8'h00);
                  state_d        = S_RESP;
               end else begin
                  opc_d   = cmd_op;
                  op1_d   = regs_q[cmd_rs1];
                  op2_d   = cmd_use_imm ? cmd_imm : regs_q[cmd_rs2];
                  rd_d    = cmd_rd;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            res_d        = alu_result;
            fz_d         = alu_flagz;
            // The ALU leaves flagc stale on non-arithmetic ops; only add/sub carry is real.
            fc_d         = ((opc_q == OP_ADD) || (opc_q == OP_SUB)) ? alu_flagc : 1'b0;
            regs_d[rd_q] = alu_result[7:0];
`ifdef ALU_CTRL_SELFCHECK_EN
            if ((ref_result(opc_q, op1_q, op2_q) != alu_result) ||
                (alu_flagz != (alu_result == 16'h0000))) begin
               chk_d = 1'b1;
            end
`endif
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any in-flight command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
         opc_q   <= 3'b000;
         op1_q   <= 8'h00;
         op2_q   <= 8'h00;
         rd_q    <= '0;
         res_q   <= 16'h0000;
         fc_q    <= 1'b0;
         fz_q    <= 1'b0;
`ifdef ALU_CTRL_SELFCHECK_EN
         chk_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         opc_q   <= opc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         fc_q    <= fc_d;
         fz_q    <= fz_d;
`ifdef ALU_CTRL_SELFCHECK_EN
         chk_q   <= chk_d;
`endif
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign alu_opcode = opc_q;
   assign alu_op1    = op1_q;
   assign alu_op2    = op2_q;
   assign rsp_result = res_q;
   assign rsp_flagc  = fc_q;
   assign rsp_flagz  = fz_q;
   assign dbg_data   = regs_q[dbg_addr];

`ifdef ALU_CTRL_SELFCHECK_EN
   assign chk_err = chk_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu8_ctrl.sv
// Bench for alu8_ctrl: behavioural ALU model, table of commands with hand-derived
// expectations, response scoreboard, plus reset-abort, backpressure and fault sequences.
module tb_alu8_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_load, cmd_use_imm;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
   logic [7:0]  cmd_imm, dbg_data;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_op1, alu_op2;
   logic [15:0] alu_result, alu_true;
   logic        alu_flagc, alu_flagz;
   logic        rsp_valid, rsp_ready, rsp_flagc, rsp_flagz, chk_err;
   logic [15:0] rsp_result;
   logic        flip;

   int errors = 0;
   int checks = 0;
   int rsp_count = 0;

   typedef struct packed {
      logic        load;
      logic [2:0]  op;
      logic [1:0]  rd, rs1, rs2;
      logic        use_imm;
      logic [7:0]  imm;
      logic [15:0] res;
      logic        c, z;
      logic [7:0]  rdv;
   } vec_t;

   typedef struct packed {
      logic [15:0] res;
      logic        c, z;
   } rsp_t;

   rsp_t exp_q [$];
   vec_t vecs [15];

   always #5 clk = ~clk;

   alu8_ctrl #(.NREG(4), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
      .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result), .alu_flagc(alu_flagc), .alu_flagz(alu_flagz),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flagc(rsp_flagc), .rsp_flagz(rsp_flagz),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .chk_err(chk_err)
   );

   // Combinational ALU; non-arithmetic ops leave a stale carry of 1 on flagc.
   always_comb begin
      alu_true = 16'h0000;
      case (alu_opcode)
         3'b000:  alu_true = {8'h00, alu_op1} + {8'h00, alu_op2};
         3'b001:  alu_true = {8'h00, alu_op1} - {8'h00, alu_op2};
         3'b010:  alu_true = {8'h00, alu_op1} * {8'h00, alu_op2};
         3'b011:  alu_true = {8'h00, alu_op1 & alu_op2};
         3'b100:  alu_true = {8'h00, alu_op1 | alu_op2};
         3'b101:  alu_true = {8'h00, ~(alu_op1 & alu_op2)};
         3'b110:  alu_true = {8'h00, ~(alu_op1 | alu_op2)};
         default: alu_true = {8'h00, alu_op1 ^ alu_op2};
      endcase
      alu_result = alu_true ^ {15'h0000, flip};
      alu_flagz  = (alu_result == 16'h0000);
      alu_flagc  = (alu_opcode == 3'b000 || alu_opcode == 3'b001) ? alu_result[8] : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic load, input logic [2:0] op, input logic [1:0] rd,
                               input logic [1:0] rs1, input logic [1:0] rs2, input logic use_imm,
                               input logic [7:0] imm, input logic [15:0] res, input logic c,
                               input logic z, input logic [7:0] rdv);
      vec_t v;
      v.load = load; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.use_imm = use_imm; v.imm = imm; v.res = res; v.c = c; v.z = z; v.rdv = rdv;
      return v;
   endfunction

   // Scoreboard: one expected response consumed per response handshake.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got result %0h with no command outstanding", rsp_result);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_result", rsp_result, e.res);
            check("rsp_flagc", rsp_flagc, e.c);
            check("rsp_flagz", rsp_flagz, e.z);
         end
         rsp_count++;
      end
   end

   task automatic drive(input vec_t v);
      cmd_load = v.load; cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1;
      cmd_rs2 = v.rs2; cmd_use_imm = v.use_imm; cmd_imm = v.imm;
      cmd_valid = 1'b1;
   endtask

   // Wait for acceptance, record expectation, then measure cycles to rsp_valid.
   task automatic accept(input vec_t v);
      bit ok = 0;
      int n = 0;
      rsp_t e;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         check("accept_timeout", 1, 0);
         cmd_valid = 1'b0;
         return;
      end
      e.res = v.res; e.c = v.c; e.z = v.z;
      exp_q.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin ok = 1; break; end
      end
      check("rsp_latency", ok ? n : 99, v.load ? 1 : 3);
   endtask

   task automatic wait_rsp(input int target);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (rsp_count >= target) begin ok = 1; break; end
      end
      check("rsp_handshake", ok, 1);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int tgt;
      tgt = rsp_count + 1;
      drive(v);
      accept(v);
      wait_rsp(tgt);
      dbg_addr = v.rd;
      #1 check("reg_writeback", dbg_data, v.rdv);
   endtask

   initial begin
      int tgt;
      logic exp_chk;
`ifdef ALU_CTRL_SELFCHECK_EN
      exp_chk = 1'b1;
`else
      exp_chk = 1'b0;
`endif
      //          load op    rd rs1 rs2 imm? imm    result    c     z     rd value
      vecs[0]  = mk(1, 3'd0, 0, 0, 0, 0, 8'hF0, 16'h00F0, 1'b0, 1'b0, 8'hF0);
      vecs[1]  = mk(1, 3'd0, 1, 0, 0, 0, 8'h20, 16'h0020, 1'b0, 1'b0, 8'h20);
      vecs[2]  = mk(0, 3'd0, 2, 0, 1, 0, 8'h00, 16'h0110, 1'b1, 1'b0, 8'h10);
      vecs[3]  = mk(1, 3'd0, 3, 0, 0, 0, 8'h03, 16'h0003, 1'b0, 1'b0, 8'h03);
      vecs[4]  = mk(0, 3'd1, 3, 3, 0, 1, 8'h05, 16'hFFFE, 1'b1, 1'b0, 8'hFE);
      vecs[5]  = mk(0, 3'd7, 3, 3, 3, 0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h00);
      vecs[6]  = mk(1, 3'd0, 0, 0, 0, 0, 8'hFF, 16'h00FF, 1'b0, 1'b0, 8'hFF);
      vecs[7]  = mk(0, 3'd2, 1, 0, 0, 0, 8'h00, 16'hFE01, 1'b0, 1'b0, 8'h01);
      vecs[8]  = mk(0, 3'd3, 2, 0, 0, 1, 8'h0F, 16'h000F, 1'b0, 1'b0, 8'h0F);
      vecs[9]  = mk(0, 3'd4, 3, 1, 2, 0, 8'h00, 16'h000F, 1'b0, 1'b0, 8'h0F);
      vecs[10] = mk(0, 3'd5, 0, 0, 0, 1, 8'hFF, 16'h0000, 1'b0, 1'b1, 8'h00);
      vecs[11] = mk(0, 3'd6, 2, 2, 0, 1, 8'h30, 16'h00C0, 1'b0, 1'b0, 8'hC0);
      vecs[12] = mk(0, 3'd0, 0, 0, 0, 1, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h00);
      vecs[13] = mk(0, 3'd1, 1, 1, 0, 1, 8'h01, 16'h0000, 1'b0, 1'b1, 8'h00);
      vecs[14] = mk(1, 3'd0, 3, 0, 0, 0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h00);

      rst = 1'b1; flip = 1'b0; rsp_ready = 1'b1; dbg_addr = 2'd0;
      cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0;
      cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_use_imm = 1'b0; cmd_imm = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_result", rsp_result, 16'h0000);
      check("reset_alu_inputs", {alu_opcode, alu_op1, alu_op2}, 19'h0);
      check("reset_chk_err", chk_err, 0);
      for (int r = 0; r < 4; r++) begin
         dbg_addr = 2'(r);
         #1 check("reset_reg", dbg_data, 8'h00);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure: response held 5 cycles while a new command waits upstream.
      run_vec(mk(1, 3'd0, 0, 0, 0, 0, 8'h7F, 16'h007F, 1'b0, 1'b0, 8'h7F));
      run_vec(mk(1, 3'd0, 1, 0, 0, 0, 8'h81, 16'h0081, 1'b0, 1'b0, 8'h81));
      rsp_ready = 1'b0;
      tgt = rsp_count + 1;
      drive(mk(0, 3'd0, 2, 0, 1, 0, 8'h00, 16'h0100, 1'b1, 1'b0, 8'h00));
      accept(mk(0, 3'd0, 2, 0, 1, 0, 8'h00, 16'h0100, 1'b1, 1'b0, 8'h00));
      @(posedge clk);
      #1;
      drive(mk(1, 3'd0, 1, 0, 0, 0, 8'h77, 16'h0077, 1'b0, 1'b0, 8'h77));
      dbg_addr = 2'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_result", rsp_result, 16'h0100);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_pending_not_taken", dbg_data, 8'h81);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      accept(mk(1, 3'd0, 1, 0, 0, 0, 8'h77, 16'h0077, 1'b0, 1'b0, 8'h77));
      wait_rsp(tgt + 1);
      dbg_addr = 2'd1;
      #1 check("bp_load_after", dbg_data, 8'h77);
      dbg_addr = 2'd2;
      #1 check("bp_add_wb", dbg_data, 8'h00);

      // Corrupted ALU result during an AND; forwarded as-is, caught only by the checker build.
      flip = 1'b1;
      run_vec(mk(0, 3'd3, 0, 1, 0, 1, 8'h0F, 16'h0006, 1'b0, 1'b0, 8'h06));
      flip = 1'b0;
      check("chk_err_set", chk_err, exp_chk);
      run_vec(mk(0, 3'd4, 0, 0, 0, 1, 8'h00, 16'h0006, 1'b0, 1'b0, 8'h06));
      check("chk_err_sticky", chk_err, exp_chk);

      // Reset while an ALU op sits in ISSUE: no response, registers cleared.
      drive(mk(0, 3'd0, 2, 0, 1, 0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00));
      @(negedge clk);
      check("abort_accept_ready", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_alu_op1", alu_op1, 8'h00);
      check("abort_chk_err", chk_err, 0);
      for (int r = 0; r < 4; r++) begin
         dbg_addr = 2'(r);
         #1 check("abort_reg", dbg_data, 8'h00);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid, 0);
      end
      check("abort_cmd_ready", cmd_ready, 1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
